// File: rtl/saper_pkg.sv
// Shared Saper board types: difficulty levels, coordinates, grid sizes and
// the fixed neighbour scan order used by the reveal sequencer.
package saper_pkg;

  localparam int COORD_BITS = 5;

  typedef enum logic [1:0] {
    LVL_NONE   = 2'd0,
    LVL_EASY   = 2'd1,
    LVL_MEDIUM = 2'd2,
    LVL_HARD   = 2'd3
  } level_t;

  typedef struct packed {
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
  } coord_t;

  // Offsets are (dx, dy) pairs, one entry per SCAN index.
  localparam logic signed [COORD_BITS:0] NBR_OFF_X [8] = '{
    -6'sd1, -6'sd1, -6'sd1, 6'sd0, 6'sd0, 6'sd1, 6'sd1, 6'sd1
  };
  localparam logic signed [COORD_BITS:0] NBR_OFF_Y [8] = '{
    -6'sd1, 6'sd0, 6'sd1, -6'sd1, 6'sd1, -6'sd1, 6'sd0, 6'sd1
  };

  function automatic logic [COORD_BITS:0] grid_size(level_t lvl);
    case (lvl)
      LVL_EASY:   return 6'd8;
      LVL_MEDIUM: return 6'd10;
      LVL_HARD:   return 6'd16;
      default:    return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO of board coordinates; pushes while full are dropped and
// flush empties it in one cycle.
module coord_fifo
  import saper_pkg::*;
#(
  parameter int QDEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  coord_t din,
  output coord_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(QDEPTH);

  coord_t         mem [QDEPTH];
  logic   [AW:0]  wr_ptr;
  logic   [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/defuse_sched.sv
// Flood-fill reveal sequencer: accepts a click, owns the defuse write port and
// expands zero-neighbour cells through a coordinate queue.
module defuse_sched
  import saper_pkg::*;
#(
  parameter int COORD_W = COORD_BITS,
  parameter int QDEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         level,
  input  logic               explode,
  input  logic               click_valid,
  input  logic [COORD_W-1:0] click_x,
  input  logic [COORD_W-1:0] click_y,
  output logic               click_ready,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic               rd_mine,
  input  logic               rd_defused,
  input  logic               rd_nbr_zero,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               hit_mine,
  output logic               busy,
  output logic               done,
  output logic               q_overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POP   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_SCAN  = 2'd3;

  logic [1:0]   state;
  coord_t       cur;
  logic         first_cell;
  logic [COORD_W:0] size_r;
  logic [2:0]   idx;
  logic         ovf_r;

  coord_t fifo_din, fifo_dout;
  logic   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

  logic signed [COORD_W:0] nx, ny, lim;
  logic [COORD_W:0]        click_size;
  logic                    nbr_ok, accept, check_open, scan_push;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    click_size  = grid_size(level_t'(level));
    click_ready = (state == S_IDLE) && (level != 2'd0);
    busy        = (state != S_IDLE);
    nx          = $signed({1'b0, cur.x}) + NBR_OFF_X[idx];
    ny          = $signed({1'b0, cur.y}) + NBR_OFF_Y[idx];
    lim         = $signed(size_r);
    nbr_ok      = !nx[COORD_W] && (nx < lim) && !ny[COORD_W] && (ny < lim);

    rd_x = cur.x;
    rd_y = cur.y;
    if (state == S_SCAN && nbr_ok) begin
      rd_x = nx[COORD_W-1:0];
      rd_y = ny[COORD_W-1:0];
    end

    accept     = click_ready && click_valid && !explode &&
                 ({1'b0, click_x} < click_size) && ({1'b0, click_y} < click_size);
    check_open = (state == S_CHECK) && !rd_mine && !rd_defused;
    wr_en      = check_open && !explode;
    wr_x       = cur.x;
    wr_y       = cur.y;
    hit_mine   = (state == S_CHECK) && rd_mine && first_cell && !explode;
    done       = (state == S_POP) && fifo_empty && !explode;
    scan_push  = (state == S_SCAN) && nbr_ok && !rd_mine && !rd_defused && !explode;

    fifo_push  = accept || scan_push;
    fifo_din   = accept ? coord_t'{x: click_x, y: click_y}
                        : coord_t'{x: nx[COORD_W-1:0], y: ny[COORD_W-1:0]};
    fifo_pop   = (state == S_POP) && !fifo_empty && !explode;
    fifo_flush = explode || hit_mine;
    q_overflow = ovf_r;
  end

  coord_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      first_cell <= 1'b0;
      size_r     <= '0;
      idx        <= '0;
      ovf_r      <= 1'b0;
    end else begin
      if (accept)                       ovf_r <= 1'b0;
      else if (fifo_push && fifo_full)  ovf_r <= 1'b1;

      if (explode) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            state      <= S_POP;
            size_r     <= click_size;
            first_cell <= 1'b1;
          end
          S_POP: if (fifo_empty) begin
            state <= S_IDLE;
          end else begin
            cur   <= fifo_dout;
            state <= S_CHECK;
          end
          S_CHECK: begin
            first_cell <= 1'b0;
            if (hit_mine)                        state <= S_IDLE;
            else if (check_open && rd_nbr_zero) begin
              state <= S_SCAN;
              idx   <= '0;
            end else                             state <= S_POP;
          end
          default: begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= S_POP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_defuse_sched.sv
// Self-checking bench for defuse_sched: emulates the board arrays and compares
// each reveal against a cell-level flood-fill model.
module tb_defuse_sched;
  import saper_pkg::*;

  localparam int CW = 5;
  localparam int QD = 16;
  localparam int BUDGET = 10000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    level;
  logic          explode, click_valid;
  logic [CW-1:0] click_x, click_y;
  logic          click_ready;
  logic [CW-1:0] rd_x, rd_y;
  logic          rd_mine, rd_defused, rd_nbr_zero;
  logic          wr_en;
  logic [CW-1:0] wr_x, wr_y;
  logic          hit_mine, busy, done, q_overflow;

  always #5 clk = ~clk;

  defuse_sched #(.COORD_W(CW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .level(level), .explode(explode),
    .click_valid(click_valid), .click_x(click_x), .click_y(click_y),
    .click_ready(click_ready), .rd_x(rd_x), .rd_y(rd_y),
    .rd_mine(rd_mine), .rd_defused(rd_defused), .rd_nbr_zero(rd_nbr_zero),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .hit_mine(hit_mine),
    .busy(busy), .done(done), .q_overflow(q_overflow)
  );

  // Board emulation, indexed [y][x].
  bit mine [16][16];
  bit nz   [16][16];
  bit defd [16][16];
  bit clr_def = 1'b0;
  int board_n;

  wire in_arr = (rd_x < 5'd16) && (rd_y < 5'd16);
  assign rd_mine     = in_arr && mine[rd_y[3:0]][rd_x[3:0]];
  assign rd_defused  = in_arr && defd[rd_y[3:0]][rd_x[3:0]];
  assign rd_nbr_zero = in_arr && nz[rd_y[3:0]][rd_x[3:0]];

  always @(posedge clk) begin
    if (clr_def) begin
      for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) defd[y][x] <= 1'b0;
    end else if (wr_en && wr_x < 5'd16 && wr_y < 5'd16) begin
      defd[wr_y[3:0]][wr_x[3:0]] <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int size_of(input int lvl);
    return (lvl == 1) ? 8 : (lvl == 2) ? 10 : (lvl == 3) ? 16 : 0;
  endfunction

  function automatic bit inside_n(input int x, input int y, input int n);
    return x >= 0 && x < n && y >= 0 && y < n;
  endfunction

  task automatic setup_board(input int lvl, input int kind, input int dens);
    int n;
    n = size_of(lvl);
    board_n = n;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) mine[y][x] = 1'b0;
    case (kind)
      1: mine[3][3] = 1'b1;
      2: mine[1][1] = 1'b1;
      3: begin
        mine[7][7] = 1'b1; mine[8][7] = 1'b1; mine[9][7] = 1'b1;
        mine[7][8] = 1'b1; mine[7][9] = 1'b1;
      end
      4: for (int y = 0; y < n; y++) for (int x = 0; x < n; x++)
           mine[y][x] = ($urandom_range(0, dens - 1) == 0);
      default: ;
    endcase
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) begin
      int c;
      c = 0;
      for (int dx = -1; dx <= 1; dx++) for (int dy = -1; dy <= 1; dy++)
        if (!(dx == 0 && dy == 0) && inside_n(x + dx, y + dy, n) && mine[y + dy][x + dx]) c++;
      nz[y][x] = (c == 0);
    end
    level   = 2'(lvl);
    clr_def = 1'b1;
    @(posedge clk); #1;
    clr_def = 1'b0;
  endtask

  // Reference model: the reveal algorithm at cell granularity.
  int exp_wr[$];
  int exp_acc, exp_hit, exp_done, exp_cycles, exp_ovf;
  int ovf_state = 0;

  task automatic model_run(input int lvl, input int cx, input int cy);
    int  n, c, cx_c, cy_c;
    int  q[$];
    bit  md [16][16];
    bit  first;
    n = size_of(lvl);
    exp_wr.delete();
    exp_hit = 0; exp_done = 0; exp_cycles = 0;
    exp_acc = (n != 0 && cx < n && cy < n) ? 1 : 0;
    if (exp_acc == 0) begin
      exp_ovf = ovf_state;
      return;
    end
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) md[y][x] = 1'b0;
    exp_ovf = 0;
    first   = 1'b1;
    q.push_back(cy * 16 + cx);
    forever begin
      exp_cycles++;
      if (q.size() == 0) begin
        exp_done = 1;
        break;
      end
      c = q.pop_front();
      exp_cycles++;
      cx_c = c % 16; cy_c = c / 16;
      if (mine[cy_c][cx_c]) begin
        if (first) begin
          exp_hit = 1;
          break;
        end
        continue;
      end
      first = 1'b0;
      if (md[cy_c][cx_c]) continue;
      md[cy_c][cx_c] = 1'b1;
      exp_wr.push_back(c);
      if (nz[cy_c][cx_c]) begin
        exp_cycles += 8;
        for (int dx = -1; dx <= 1; dx++) for (int dy = -1; dy <= 1; dy++) begin
          int px, py;
          px = cx_c + dx; py = cy_c + dy;
          if ((dx == 0 && dy == 0) || !inside_n(px, py, n)) continue;
          if (mine[py][px] || md[py][px]) continue;
          if (q.size() >= QD) exp_ovf = 1;
          else q.push_back(py * 16 + px);
        end
      end
      first = 1'b0;
    end
    ovf_state = exp_ovf;
  endtask

  int act_wr[$];
  int act_acc, act_hit, act_done, act_cycles, ready_bad;

  // Entered and left #1 after a rising edge.
  task automatic run_click(input int cx, input int cy, input bit noisy);
    int cyc;
    act_wr.delete();
    act_hit = 0; act_done = 0; ready_bad = 0;
    click_x = 5'(cx); click_y = 5'(cy); click_valid = 1'b1;
    @(posedge clk); #1;
    if (noisy) begin
      click_x = 5'd15; click_y = 5'd15;
    end else begin
      click_valid = 1'b0;
    end
    act_acc = int'(busy);
    cyc = 0;
    while (busy && cyc < BUDGET) begin
      cyc++;
      if (wr_en)       act_wr.push_back(int'(wr_y) * 16 + int'(wr_x));
      if (hit_mine)    act_hit++;
      if (done)        act_done++;
      if (click_ready) ready_bad++;
      if (noisy)       level = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    click_valid = 1'b0;
    if (busy) check("run_timeout", 1, 0);
    act_cycles = cyc;
  endtask

  task automatic compare_run(input string tag);
    int mism;
    check({tag, " accept"}, act_acc, exp_acc);
    check({tag, " cycles"}, act_cycles, exp_cycles);
    check({tag, " hit_mine"}, act_hit, exp_hit);
    check({tag, " done"}, act_done, exp_done);
    check({tag, " q_overflow"}, int'(q_overflow), exp_ovf);
    check({tag, " wr_count"}, act_wr.size(), exp_wr.size());
    mism = 0;
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
      if (act_wr[i] != exp_wr[i]) mism++;
    check({tag, " wr_seq_mismatches"}, mism, 0);
  endtask

  task automatic do_test(input int lvl, input int kind, input int dens,
                         input int cx, input int cy, input bit noisy, input string tag);
    setup_board(lvl, kind, dens);
    model_run(lvl, cx, cy);
    run_click(cx, cy, noisy);
    level = 2'(lvl);
    compare_run(tag);
  endtask

  typedef struct {
    int lvl, board, cx, cy;
    int acc, nwr, ndone, nhit, cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 1, 3, 3,   1, 0, 0, 1, 2};
    vecs[1] = '{1, 2, 0, 0,   1, 1, 1, 0, 3};
    vecs[2] = '{1, 0, 12, 0,  0, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[4] = '{2, 3, 9, 9,   1, 4, 1, 0, 17};
    vecs[5] = '{1, 2, 1, 1,   1, 0, 0, 1, 2};
    vecs[6] = '{1, 2, 8, 3,   0, 0, 0, 0, 0};
    vecs[7] = '{2, 1, 10, 0,  0, 0, 0, 0, 0};
    vecs[8] = '{3, 1, 3, 3,   1, 0, 0, 1, 2};

    rst = 1'b1; level = 2'd0; explode = 1'b0; click_valid = 1'b0;
    click_x = '0; click_y = '0; board_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset click_ready", int'(click_ready), 0);
    check("reset wr_en", int'(wr_en), 0);
    check("reset done", int'(done), 0);
    check("reset hit_mine", int'(hit_mine), 0);
    check("reset q_overflow", int'(q_overflow), 0);
    check("reset rd_addr", int'({rd_x, rd_y}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_test(vecs[i].lvl, vecs[i].board, 1, vecs[i].cx, vecs[i].cy, 1'b0, tag);
      check({tag, " tbl_accept"}, act_acc, vecs[i].acc);
      check({tag, " tbl_writes"}, act_wr.size(), vecs[i].nwr);
      check({tag, " tbl_done"}, act_done, vecs[i].ndone);
      check({tag, " tbl_hit"}, act_hit, vecs[i].nhit);
      check({tag, " tbl_cycles"}, act_cycles, vecs[i].cyc);
    end

    // Medium corner: exact write order and no address beyond the 10x10 grid.
    do_test(2, 3, 1, 9, 9, 1'b0, "corner");
    begin
      int want[4];
      int maxc;
      want = '{9 * 16 + 9, 8 * 16 + 8, 9 * 16 + 8, 8 * 16 + 9};
      maxc = 0;
      foreach (act_wr[i]) begin
        if (act_wr[i] % 16 > maxc) maxc = act_wr[i] % 16;
        if (act_wr[i] / 16 > maxc) maxc = act_wr[i] / 16;
      end
      check("corner max_coord", maxc, 9);
      for (int i = 0; i < 4; i++)
        check($sformatf("corner wr%0d", i), (i < act_wr.size()) ? act_wr[i] : -1, want[i]);
    end

    // Hard empty board with click held and level wiggled while busy.
    do_test(3, 0, 1, 0, 0, 1'b1, "hard_flood");
    check("hard_flood click_ready_while_busy", ready_bad, 0);
    begin
      int dup;
      dup = 0;
      for (int i = 0; i < act_wr.size(); i++)
        for (int j = i + 1; j < act_wr.size(); j++)
          if (act_wr[i] == act_wr[j]) dup++;
      check("hard_flood duplicate_writes", dup, 0);
    end

    // Explode mid-SCAN.
    setup_board(3, 0, 1);
    click_x = 5'd5; click_y = 5'd5; click_valid = 1'b1;
    @(posedge clk); #1;
    click_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("explode pre busy", int'(busy), 1);
    explode = 1'b1;
    #1;
    check("explode cycle wr_en", int'(wr_en), 0);
    check("explode cycle done", int'(done), 0);
    @(posedge clk); #1;
    explode = 1'b0;
    check("explode busy_next", int'(busy), 0);
    begin
      int bad;
      bad = 0;
      repeat (20) begin
        if (wr_en || done || busy) bad++;
        @(posedge clk); #1;
      end
      check("explode quiet_after", bad, 0);
    end
    ovf_state = 0;
    do_test(1, 2, 1, 0, 0, 1'b0, "post_explode");

    // Explode wins over a click in IDLE.
    explode = 1'b1;
    click_x = 5'd2; click_y = 5'd2; click_valid = 1'b1;
    @(posedge clk); #1;
    click_valid = 1'b0; explode = 1'b0;
    check("explode_vs_click busy", int'(busy), 0);

    // Randomised boards.
    for (int r = 0; r < 20; r++) begin
      int lvl, n;
      lvl = $urandom_range(1, 3);
      n = size_of(lvl);
      do_test(lvl, 4, $urandom_range(3, 8), $urandom_range(0, n + 1),
              $urandom_range(0, n + 1), 1'b0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a reveal.
    do_test(3, 0, 1, 0, 0, 1'b0, "pre_reset");
    setup_board(3, 0, 1);
    click_x = 5'd7; click_y = 5'd7; click_valid = 1'b1;
    @(posedge clk); #1;
    click_valid = 1'b0;
    check("mid_pop busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", int'(busy), 0);
    check("async_rst wr_en", int'(wr_en), 0);
    check("async_rst done", int'(done), 0);
    check("async_rst hit_mine", int'(hit_mine), 0);
    check("async_rst q_overflow", int'(q_overflow), 0);
    check("async_rst addr", int'({rd_x, rd_y, wr_x, wr_y}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ovf_state = 0;
    do_test(1, 2, 1, 0, 0, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
